// File: rtl/fp_sp_pkg.sv
// Shared single-precision constants and types for the fp_*_sp datapath
// blocks (adder and multiplier).
//   - field widths of an IEEE-754 single
//   - exponent bias, largest biased exponent, canonical quiet NaN
//   - special-case tag carried down a pipeline next to the datapath
package fp_sp_pkg;

  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [EXP_W-1:0] EXP_ONES = 8'hFF;
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  // Result class decided before the datapath finishes; TAG_NONE means the
  // normal round-and-pack result is used.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_ZERO = 2'd1,
    TAG_INF  = 2'd2,
    TAG_NAN  = 2'd3
  } special_tag_e;

endpackage

// File: rtl/fp_lzc28.sv
// Combinational 28-bit leading-zero counter.
// Ports:
//   i_data  [27:0] : word to scan, bit 27 is the most significant
//   o_count [4:0]  : number of zeros above the first 1 (28 when all zero)
module fp_lzc28 (
  input  logic [27:0] i_data,
  output logic [4:0]  o_count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_count = 5'd28;
    for (int i = 0; i <= 27; i++) begin
      if (i_data[i]) begin
        o_count = 5'(27 - i);
      end
    end
  end

endmodule

// File: rtl/fp_add_sp.sv
// Pipelined IEEE-754 single-precision adder, round-to-nearest-even,
// flush-to-zero on both input and output. One operand pair per clock,
// fixed latency of 5 cycles from the sampling edge, no backpressure.
// Ports:
//   i_CLK, i_RST        : clock, synchronous active-high reset
//   i_VALID, i_A, i_B   : operand pair strobe and operands
//   o_VALID, o_RES      : result strobe and sum (held while o_VALID is 0)
//   o_INF, o_NaN, o_DENORMAL, o_ZERO : class of o_RES (held with it)
module fp_add_sp
  import fp_sp_pkg::*;
#(
  parameter int P_LATENCY = 5
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_VALID,
  input  logic signed [31:0] i_A,
  input  logic signed [31:0] i_B,
  output logic               o_VALID,
  output logic signed [31:0] o_RES,
  output logic               o_INF,
  output logic               o_NaN,
  output logic               o_DENORMAL,
  output logic               o_ZERO
);

  if (P_LATENCY != 5) begin : g_bad_latency
    $error("fp_add_sp: P_LATENCY must be 5");
  end

  localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

  // input capture
  logic        v0_d, v0_q;
  logic [31:0] a0_d, a0_q, b0_d, b0_q;

  // S1: unpack and swap
  logic         v1_d, v1_q;
  special_tag_e tag1_d, tag1_q;
  logic         sign1_d, sign1_q, sub1_d, sub1_q;
  logic [7:0]   ex1_d, ex1_q, d1_d, d1_q;
  logic [23:0]  mx1_d, mx1_q, my1_d, my1_q;

  // S2: align
  logic         v2_d, v2_q;
  special_tag_e tag2_d, tag2_q;
  logic         sign2_d, sign2_q, sub2_d, sub2_q;
  logic [7:0]   ex2_d, ex2_q;
  logic [26:0]  mx2_d, mx2_q, my2_d, my2_q;

  // S3: add/subtract
  logic               v3_d, v3_q;
  special_tag_e       tag3_d, tag3_q;
  logic               sign3_d, sign3_q;
  logic signed [9:0]  ex3_d, ex3_q;
  logic [27:0]        sum3_d, sum3_q;

  // S4: normalize
  logic               v4_d, v4_q;
  special_tag_e       tag4_d, tag4_q;
  logic               sign4_d, sign4_q;
  logic signed [9:0]  ex4_d, ex4_q;
  logic [26:0]        m4_d, m4_q;

  // S5: round, pack, classify
  logic        out_valid_d, out_valid_q;
  logic [31:0] res_d, res_q;
  logic        inf_d, inf_q, nan_d, nan_q, den_d, den_q, zero_d, zero_q;

  always_comb begin
    v0_d = i_VALID;
    a0_d = i_A;
    b0_d = i_B;
  end

  // ---------------- S1 ----------------
  logic        sa, sb, a_nan, b_nan, a_inf, b_inf, a_ge_b;
  logic [7:0]  ea, eb, ex, ey;
  logic [22:0] fa, fb, fx, fy;

  always_comb begin
    sa = a0_q[31];
    sb = b0_q[31];
    ea = a0_q[30:23];
    eb = b0_q[30:23];
    // Denormal inputs are flushed to a signed zero.
    fa = (ea == 8'd0) ? 23'd0 : a0_q[22:0];
    fb = (eb == 8'd0) ? 23'd0 : b0_q[22:0];

    a_nan = (ea == EXP_ONES) && (fa != 23'd0);
    b_nan = (eb == EXP_ONES) && (fb != 23'd0);
    a_inf = (ea == EXP_ONES) && (fa == 23'd0);
    b_inf = (eb == EXP_ONES) && (fb == 23'd0);

    a_ge_b = {ea, fa} >= {eb, fb};
    ex = a_ge_b ? ea : eb;
    ey = a_ge_b ? eb : ea;
    fx = a_ge_b ? fa : fb;
    fy = a_ge_b ? fb : fa;

    v1_d    = v0_q;
    tag1_d  = TAG_NONE;
    sign1_d = a_ge_b ? sa : sb;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      tag1_d = TAG_NAN;
    end else if (a_inf) begin
      tag1_d  = TAG_INF;
      sign1_d = sa;
    end else if (b_inf) begin
      tag1_d  = TAG_INF;
      sign1_d = sb;
    end else if ((ea == 8'd0) && (eb == 8'd0)) begin
      // Sum of two zeros is -0 only when both are -0.
      tag1_d  = TAG_ZERO;
      sign1_d = sa & sb;
    end

    sub1_d = sa ^ sb;
    ex1_d  = ex;
    // Hidden bit only for normal numbers, so a flushed zero contributes 0.
    mx1_d  = {ex != 8'd0, fx};
    my1_d  = {ey != 8'd0, fy};
    d1_d   = ex - ey;
  end

  // ---------------- S2 ----------------
  logic [26:0] my_ext, my_shift, shift_mask;

  always_comb begin
    v2_d    = v1_q;
    tag2_d  = tag1_q;
    sign2_d = sign1_q;
    sub2_d  = sub1_q;
    ex2_d   = ex1_q;
    mx2_d   = {mx1_q, 3'b000};

    my_ext     = {my1_q, 3'b000};
    my_shift   = '0;
    shift_mask = '0;
    if (d1_q >= 8'd27) begin
      my2_d = {26'd0, |my1_q};
    end else begin
      my_shift   = my_ext >> d1_q;
      shift_mask = (27'd1 << d1_q) - 27'd1;
      my2_d      = {my_shift[26:1], my_shift[0] | (|(my_ext & shift_mask))};
    end
  end

  // ---------------- S3 ----------------
  always_comb begin
    v3_d    = v2_q;
    tag3_d  = tag2_q;
    sign3_d = sign2_q;
    ex3_d   = $signed({2'b00, ex2_q});
    // |X| >= |Y| after the swap, so the difference never goes negative.
    if (sub2_q) begin
      sum3_d = {1'b0, mx2_q} - {1'b0, my2_q};
    end else begin
      sum3_d = {1'b0, mx2_q} + {1'b0, my2_q};
    end
    if ((tag2_q == TAG_NONE) && (sum3_d == 28'd0)) begin
      tag3_d  = TAG_ZERO;
      sign3_d = 1'b0;
    end
  end

  // ---------------- S4 ----------------
  logic [4:0] lzc_count, lz_shift;

  fp_lzc28 u_lzc (
    .i_data  (sum3_q),
    .o_count (lzc_count)
  );

  always_comb begin
    v4_d    = v3_q;
    tag4_d  = tag3_q;
    sign4_d = sign3_q;
    // Bit 27 is clear on this path, so the 27-bit field's shift is lzc-1.
    lz_shift = lzc_count - 5'd1;
    if (sum3_q[27]) begin
      m4_d  = {sum3_q[27:2], sum3_q[1] | sum3_q[0]};
      ex4_d = ex3_q + 10'sd1;
    end else begin
      m4_d  = sum3_q[26:0] << lz_shift;
      ex4_d = ex3_q - $signed({5'b00000, lz_shift});
    end
    if ((tag3_q == TAG_NONE) && (ex4_d <= 10'sd0)) begin
      tag4_d = TAG_ZERO;
    end
  end

  // ---------------- S5 ----------------
  logic [23:0]       mant24;
  logic [24:0]       mant25;
  logic              rnd_up;
  logic [22:0]       frac;
  logic signed [9:0] ex5;

  always_comb begin
    mant24 = m4_q[26:3];
    rnd_up = m4_q[2] & (m4_q[3] | m4_q[1] | m4_q[0]);
    mant25 = {1'b0, mant24} + {24'd0, rnd_up};
    if (mant25[24]) begin
      frac = mant25[23:1];
      ex5  = ex4_q + 10'sd1;
    end else begin
      frac = mant25[22:0];
      ex5  = ex4_q;
    end

    case (tag4_q)
      TAG_NAN:  res_d = QNAN;
      TAG_INF:  res_d = {sign4_q, EXP_ONES, 23'd0};
      TAG_ZERO: res_d = {sign4_q, 31'd0};
      default: begin
        if (ex5 >= EXP_MAX_S) begin
          res_d = {sign4_q, EXP_ONES, 23'd0};
        end else begin
          res_d = {sign4_q, ex5[7:0], frac};
        end
      end
    endcase

    out_valid_d = v4_q;
    inf_d  = (res_d[30:23] == EXP_ONES) && (res_d[22:0] == 23'd0);
    nan_d  = (res_d[30:23] == EXP_ONES) && (res_d[22:0] != 23'd0);
    den_d  = (res_d[30:23] == 8'd0);
    zero_d = (res_d[30:0] == 31'd0);
  end

  always_ff @(posedge i_CLK) begin
    // datapath registers: no reset needed, qualified by the valid bits
    a0_q    <= a0_d;
    b0_q    <= b0_d;
    tag1_q  <= tag1_d;
    sign1_q <= sign1_d;
    sub1_q  <= sub1_d;
    ex1_q   <= ex1_d;
    mx1_q   <= mx1_d;
    my1_q   <= my1_d;
    d1_q    <= d1_d;
    tag2_q  <= tag2_d;
    sign2_q <= sign2_d;
    sub2_q  <= sub2_d;
    ex2_q   <= ex2_d;
    mx2_q   <= mx2_d;
    my2_q   <= my2_d;
    tag3_q  <= tag3_d;
    sign3_q <= sign3_d;
    ex3_q   <= ex3_d;
    sum3_q  <= sum3_d;
    tag4_q  <= tag4_d;
    sign4_q <= sign4_d;
    ex4_q   <= ex4_d;
    m4_q    <= m4_d;

    if (i_RST) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      v4_q        <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      inf_q       <= 1'b0;
      nan_q       <= 1'b0;
      den_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      v4_q        <= v4_d;
      out_valid_q <= out_valid_d;
      if (v4_q) begin
        res_q  <= res_d;
        inf_q  <= inf_d;
        nan_q  <= nan_d;
        den_q  <= den_d;
        zero_q <= zero_d;
      end
    end
  end

  assign o_VALID    = out_valid_q;
  assign o_RES      = res_q;
  assign o_INF      = inf_q;
  assign o_NaN      = nan_q;
  assign o_DENORMAL = den_q;
  assign o_ZERO     = zero_q;

endmodule

// File: tb/tb_fp_add_sp.sv
module tb_fp_add_sp;

  logic               clk = 1'b0;
  logic               rst;
  logic               vin;
  logic signed [31:0] a, b;
  logic               o_valid;
  logic signed [31:0] o_res;
  logic               o_inf, o_nan, o_den, o_zero;
  logic [3:0]         flags_now;

  int n_cmp = 0;
  int n_bad = 0;

  fp_add_sp #(.P_LATENCY(5)) dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_VALID    (vin),
    .i_A        (a),
    .i_B        (b),
    .o_VALID    (o_valid),
    .o_RES      (o_res),
    .o_INF      (o_inf),
    .o_NaN      (o_nan),
    .o_DENORMAL (o_den),
    .o_ZERO     (o_zero)
  );

  always #5 clk = ~clk;

  assign flags_now = {o_inf, o_nan, o_den, o_zero};

  // Exact reference: align both significands onto a common integer grid,
  // add exactly in 64 bits, then round the magnitude to 24 bits (RNE).
  // Valid for normal operands whose exponents differ by less than ~30.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    int                 ex, ey, emin, p, sh, e;
    logic signed [63:0] vx, vy, s;
    logic [63:0]        mag, mant, rem, half;
    logic               sgn;
    ex   = int'(x[30:23]);
    ey   = int'(y[30:23]);
    emin = (ex < ey) ? ex : ey;
    vx   = {40'd0, 1'b1, x[22:0]};
    vy   = {40'd0, 1'b1, y[22:0]};
    vx   = vx <<< (ex - emin);
    vy   = vy <<< (ey - emin);
    if (x[31]) vx = -vx;
    if (y[31]) vy = -vy;
    s = vx + vy;
    if (s == 64'sd0) return 32'h0000_0000;
    sgn = s[63];
    mag = sgn ? 64'(-s) : 64'(s);
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    if (p <= 23) begin
      mant = mag << (23 - p);
      e    = emin + p - 23;
    end else begin
      sh   = p - 23;
      mant = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      e    = emin + sh;
      if ((rem > half) || ((rem == half) && mant[0])) mant = mant + 64'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e    = e + 1;
      end
    end
    return {sgn, 8'(e), mant[22:0]};
  endfunction

  task automatic apply_pair(input logic [31:0] xa, input logic [31:0] xb,
                            output logic [31:0] res, output logic [3:0] flg, output int lat);
    @(negedge clk);
    a = xa; b = xb; vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    lat = -1; res = '0; flg = '0;
    for (int k = 1; k <= 10; k++) begin
      if (lat < 0) begin
        @(posedge clk); #1;
        if (o_valid) begin
          lat = k; res = o_res; flg = flags_now;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_res !== 32'h0) begin n_bad++; $display("FAIL reset_res: got %h want 00000000", o_res); end
    n_cmp++; if (flags_now !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", flags_now); end
    @(negedge clk);
    rst = 1'b0; vin = 1'b0;
  endtask

  task automatic test_one_plus_one();
    logic [31:0] r; logic [3:0] f; int lat;
    apply_pair(32'h3F80_0000, 32'h3F80_0000, r, f, lat);
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL one_plus_one_latency: got %0d want 5", lat); end
    n_cmp++; if (r !== 32'h4000_0000) begin n_bad++; $display("FAIL one_plus_one_res: got %h want 40000000", r); end
    n_cmp++; if (f !== 4'b0000) begin n_bad++; $display("FAIL one_plus_one_flags: got %b want 0000", f); end
    @(posedge clk); #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL one_plus_one_pulse: o_VALID got %b want 0", o_valid); end
  endtask

  task automatic test_cancellation();
    logic [31:0] ta [3] = '{32'h3F80_0000, 32'h4049_0FDB, 32'h3F80_0001};
    logic [31:0] tb [3] = '{32'hBF80_0000, 32'hC049_0FDB, 32'hBF80_0000};
    logic [31:0] tr [3] = '{32'h0000_0000, 32'h0000_0000, 32'h3400_0000};
    logic [3:0]  tf [3] = '{4'b0011, 4'b0011, 4'b0000};
    logic [31:0] r; logic [3:0] f; int lat;
    for (int i = 0; i < 3; i++) begin
      apply_pair(ta[i], tb[i], r, f, lat);
      n_cmp++; if (r !== tr[i]) begin n_bad++; $display("FAIL cancel_res[%0d]: got %h want %h", i, r, tr[i]); end
      n_cmp++; if (f !== tf[i]) begin n_bad++; $display("FAIL cancel_flags[%0d]: got %b want %b", i, f, tf[i]); end
    end
  endtask

  task automatic test_rne_ties();
    logic [31:0] ta [3] = '{32'h3F80_0000, 32'h3F80_0001, 32'h3FFF_FFFF};
    logic [31:0] tb [3] = '{32'h3380_0000, 32'h3380_0000, 32'h3380_0000};
    logic [31:0] tr [3] = '{32'h3F80_0000, 32'h3F80_0002, 32'h4000_0000};
    logic [31:0] r; logic [3:0] f; int lat;
    for (int i = 0; i < 3; i++) begin
      apply_pair(ta[i], tb[i], r, f, lat);
      n_cmp++; if (r !== tr[i]) begin n_bad++; $display("FAIL rne_res[%0d]: got %h want %h", i, r, tr[i]); end
      n_cmp++; if (f !== 4'b0000) begin n_bad++; $display("FAIL rne_flags[%0d]: got %b want 0000", i, f); end
    end
  endtask

  task automatic test_overflow_specials();
    logic [31:0] ta [5] = '{32'h7F7F_FFFF, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h7F80_0000};
    logic [31:0] tb [5] = '{32'h7F7F_FFFF, 32'hFF80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000};
    logic [31:0] tr [5] = '{32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0000};
    logic [3:0]  tf [5] = '{4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
    logic [31:0] r; logic [3:0] f; int lat;
    for (int i = 0; i < 5; i++) begin
      apply_pair(ta[i], tb[i], r, f, lat);
      n_cmp++; if (r !== tr[i]) begin n_bad++; $display("FAIL special_res[%0d]: got %h want %h", i, r, tr[i]); end
      n_cmp++; if (f !== tf[i]) begin n_bad++; $display("FAIL special_flags[%0d]: got %b want %b", i, f, tf[i]); end
    end
  endtask

  task automatic test_flush_to_zero();
    logic [31:0] ta [4] = '{32'h0000_0001, 32'h8000_0000, 32'h8080_0001, 32'h0040_0000};
    logic [31:0] tb [4] = '{32'h3F80_0000, 32'h8000_0000, 32'h0080_0000, 32'h0040_0000};
    logic [31:0] tr [4] = '{32'h3F80_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [3:0]  tf [4] = '{4'b0000, 4'b0011, 4'b0011, 4'b0011};
    logic [31:0] r; logic [3:0] f; int lat;
    for (int i = 0; i < 4; i++) begin
      apply_pair(ta[i], tb[i], r, f, lat);
      n_cmp++; if (r !== tr[i]) begin n_bad++; $display("FAIL ftz_res[%0d]: got %h want %h", i, r, tr[i]); end
      n_cmp++; if (f !== tf[i]) begin n_bad++; $display("FAIL ftz_flags[%0d]: got %b want %b", i, f, tf[i]); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] r; logic [3:0] f; int lat;
    apply_pair(32'h4040_0000, 32'h3F80_0000, r, f, lat);
    n_cmp++; if (r !== 32'h4080_0000) begin n_bad++; $display("FAIL hold_res: got %h want 40800000", r); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want 0", i, o_valid); end
      n_cmp++; if (o_res !== 32'h4080_0000) begin n_bad++; $display("FAIL hold_value[%0d]: got %h want 40800000", i, o_res); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ina [12], inb [12], want [12];
    logic [13:0] pat;
    logic        exp_v;
    int          pi, oi;
    pat = 14'b11110011111111;
    for (int i = 0; i < 12; i++) begin
      ina[i]  = {1'($urandom), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
      inb[i]  = {1'($urandom), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
      want[i] = ref_add(ina[i], inb[i]);
    end
    pi = 0; oi = 0;
    for (int cyc = 0; cyc < 21; cyc++) begin
      @(negedge clk);
      if ((cyc < 14) && pat[cyc]) begin
        a = ina[pi]; b = inb[pi]; vin = 1'b1; pi++;
      end else begin
        vin = 1'b0;
      end
      @(posedge clk); #1;
      exp_v = ((cyc >= 5) && (cyc < 19)) ? pat[cyc-5] : 1'b0;
      n_cmp++; if (o_valid !== exp_v) begin n_bad++; $display("FAIL stream_valid[cyc %0d]: got %b want %b", cyc, o_valid, exp_v); end
      if (exp_v) begin
        n_cmp++;
        if (o_res !== want[oi]) begin
          n_bad++; $display("FAIL stream_res[%0d]: %h + %h got %h want %h", oi, ina[oi], inb[oi], o_res, want[oi]);
        end
        oi++;
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] sa [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F80_0000};
    logic [31:0] sb [5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
    logic        exp_v;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      rst = (cyc == 3);
      vin = (cyc <= 4);
      if (cyc <= 4) begin a = sa[cyc]; b = sb[cyc]; end
      @(posedge clk); #1;
      if (cyc == 3) begin
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_res !== 32'h0) begin n_bad++; $display("FAIL midrst_res: got %h want 00000000", o_res); end
        n_cmp++; if (flags_now !== 4'b0000) begin n_bad++; $display("FAIL midrst_flags: got %b want 0000", flags_now); end
      end else begin
        exp_v = (cyc == 9);
        n_cmp++; if (o_valid !== exp_v) begin n_bad++; $display("FAIL midrst_stream_valid[cyc %0d]: got %b want %b", cyc, o_valid, exp_v); end
        if (cyc == 9) begin
          n_cmp++; if (o_res !== 32'h4040_0000) begin n_bad++; $display("FAIL midrst_res_after: got %h want 40400000", o_res); end
        end
      end
    end
    @(negedge clk);
    rst = 1'b0; vin = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; a = '0; b = '0;
    test_reset();
    test_one_plus_one();
    test_cancellation();
    test_rne_ties();
    test_overflow_specials();
    test_flush_to_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_add_sp.md
# fp_add_sp

Pipelined IEEE-754 single-precision adder that sits directly downstream of `fp_mult_sp`. It accepts one operand pair per clock and sums products into partial results for dot-product and MAC datapaths. It carries a valid bit through a fixed 5-stage pipeline and rounds to nearest-even. It reports the same INF/NaN/DENORMAL/ZERO classification as the multiplier, taken from the final result.

## Interface
Parameters:
- `P_LATENCY`, 5: pipeline depth in cycles. Fixed; any other value is rejected at elaboration.

Ports:
- `i_CLK`  in  1: clock; all logic is on the rising edge.
- `i_RST`  in  1: reset, synchronous and active-high.
- `i_VALID`  in  1: the operand pair on `i_A`/`i_B` is valid this cycle.
- `i_A`  in  signed 32: operand A (IEEE-754 single).
- `i_B`  in  signed 32: operand B (IEEE-754 single).
- `o_VALID`  out  1: `o_RES` and the flags carry a new result this cycle.
- `o_RES`  out  signed 32: sum.
- `o_INF`  out  1: result exponent is all ones and the fraction is zero.
- `o_NaN`  out  1: result exponent is all ones and the fraction is non-zero.
- `o_DENORMAL`  out  1: result exponent is zero. This is also set for zero results.
- `o_ZERO`  out  1: result exponent and fraction are both zero.

## Operation
- Flush-to-zero on input: an operand with exponent 0 is treated as ±0, keeping its sign.
- Special cases are resolved in S1 and carried as a tag to the output stage.
  - Either operand NaN, or +inf added to −inf: result is 32'h7FC00000.
  - Exactly one inf, or two infs of the same sign: result is that inf.
- S1, unpack and swap:
  - Prepend the hidden 1.
  - Order the operands so that |X| ≥ |Y|, comparing the exponent first and then the fraction.
  - d = eX − eY (8 bits, unsigned).
  - Result sign = sign of X. Effective operation is subtract when the input signs differ.
- S2, align: shift mY right by d into a 27-bit field of 24 mantissa bits plus guard, round and sticky. Sticky is the OR of every bit shifted past. If d ≥ 27, Y reduces to sticky only.
- S3, add/subtract: 28-bit sum/difference of the aligned fields. An exact zero difference gives +0.
- S4, normalize:
  - On carry-out, shift right by 1 and add 1 to the exponent, folding the dropped bit into sticky.
  - Otherwise shift left by the leading-zero count (0..26) and subtract it from the exponent.
  - If the exponent drops to ≤ 0, the result is ±0 with sign kept (flush-to-zero on output).
- S5, round and pack:
  - Round up when G & (LSB | R | S).
  - If rounding carries out of the mantissa, shift right by 1 and add 1 to the exponent.
  - If the exponent is ≥ 255, the result is ±inf.
  - Pack {sign, exp[7:0], frac[22:0]} and derive the four flags from the packed word.
- Exponent arithmetic is 10-bit signed internally to hold the overflow and underflow range. It is truncated to 8 bits only after the range checks.

## Timing
- Latency: a pair sampled with `i_VALID`=1 at edge N appears with `o_VALID`=1 after edge N+5.
- Throughput: one pair per cycle. There is no backpressure and no stall input.
- Stages with valid=0 do not update `o_RES` or the flags; those outputs hold their last value. `o_VALID` falls to 0 one cycle after the last valid result.
- Reset values: `o_VALID`, `o_RES`, `o_INF`, `o_NaN`, `o_DENORMAL`, `o_ZERO` are all 0, and every stage valid bit is cleared.
- Reset mid-stream: every in-flight beat is discarded, with no `o_VALID` for it. A beat presented in the same cycle as `i_RST` is also discarded.
- The first valid input after `i_RST` deasserts produces its result exactly 5 cycles later.

## Structure
- Shared package `fp_sp_pkg`:
  - constants for bias 127, `EXP_MAX` 255, and `QNAN` 32'h7FC00000;
  - field widths (sign 1, exponent 8, fraction 23);
  - the special-case tag enum: none, zero, inf, nan.
- `fp_mult_sp` moves its constants to `fp_sp_pkg` as well.
- One sub-module, `fp_lzc28`: a combinational 28-bit leading-zero counter with a 5-bit count, used in S4.

## Test plan
- 1.0 plus 1.0: 3F800000 + 3F800000 with a single `i_VALID` pulse gives 40000000 and all flags 0. `o_VALID` is high for exactly one cycle, 5 cycles after input.
- Cancellation: 3F800000 + BF800000 gives 00000000, with `o_ZERO`=1 and `o_DENORMAL`=1.
- Round-to-nearest-even ties:
  - 3F800000 + 33800000 gives 3F800000 (tie, even LSB, no round-up).
  - 3F800001 + 33800000 gives 3F800002 (tie, odd LSB, round-up).
- Overflow and specials:
  - 7F7FFFFF + 7F7FFFFF gives 7F800000 with `o_INF`=1.
  - 7F800000 + FF800000 gives 7FC00000 with `o_NaN`=1.
- Streaming: 8 back-to-back pairs with random finite operands, then a 2-cycle `i_VALID` gap, then 4 more pairs. Results match a golden model with flush-to-zero and RNE, in order. `o_VALID` mirrors the input pattern delayed by 5 cycles.
- Reset mid-stream: present 3 valid pairs, assert `i_RST` for 1 cycle, then present 1 pair. Only the last pair produces `o_VALID`, 5 cycles after it was presented. All outputs read 0 in the cycle after reset.
